// File: rtl/sdram_arbiter_pkg.sv
// Shared constants for the two-port SDRAM request arbiter: state encodings,
// grant identifiers and controller request-bundle widths.
package sdram_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    localparam logic GNT_P0 = 1'b0;
    localparam logic GNT_P1 = 1'b1;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] SEL_FULL_WORD = 2'b11;

    function automatic logic [1:0] state_for_grant(input logic gnt);
        return (gnt == GNT_P1) ? ST_GRANT1 : ST_GRANT0;
    endfunction

endpackage

// File: rtl/sdram_arb_prio.sv
// Winner select for the arbiter: port 0 has priority unless port 1 has been
// passed over MAX_STARVE times in a row while waiting.
module sdram_arb_prio
    import sdram_arbiter_pkg::*;
#(
    parameter int MAX_STARVE = 4,
    parameter int STARVE_W   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic p0_req_i,
    input  logic p1_req_i,
    input  logic load_i,
    output logic winner_o
);

    logic [STARVE_W-1:0] starve_cnt_q;
    logic [STARVE_W-1:0] starve_cnt_d;
    logic                starved;

    assign starved  = (starve_cnt_q == STARVE_W'(MAX_STARVE));
    assign winner_o = (p1_req_i && (starved || !p0_req_i)) ? GNT_P1 : GNT_P0;

    // The count only means something while port 1 is actually waiting.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!p1_req_i) begin
            starve_cnt_d = '0;
        end else if (load_i) begin
            if (winner_o == GNT_P1) begin
                starve_cnt_d = '0;
            end else if (!starved) begin
                starve_cnt_d = starve_cnt_q + STARVE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of the SDRAM controller request interface:
// port 0 is the latency-critical flash-emulation read path, port 1 bulk host.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_STARVE = 4,
    parameter int STARVE_W   = 3
) (
    input  logic                  sdram_clk,
    input  logic                  sdram_rst_n,

    input  logic                  p0_acc_i,
    input  logic [ADDR_WIDTH-1:0] p0_adr_i,
    output logic                  p0_ack_o,
    output logic                  p0_ack_raw_o,
    output logic [DATA_W-1:0]     p0_dat_o,
    input  logic                  p0_hold_i,
    input  logic                  p0_pause_i,

    input  logic                  p1_acc_i,
    input  logic                  p1_we_i,
    input  logic [ADDR_WIDTH-1:0] p1_adr_i,
    input  logic [DATA_W-1:0]     p1_dat_i,
    input  logic [SEL_W-1:0]      p1_sel_i,
    output logic                  p1_ack_o,
    output logic [DATA_W-1:0]     p1_dat_o,

    output logic                  ctl_acc_o,
    output logic                  ctl_we_o,
    output logic [ADDR_WIDTH-1:0] ctl_adr_o,
    output logic [DATA_W-1:0]     ctl_dat_o,
    output logic [SEL_W-1:0]      ctl_sel_o,
    input  logic                  ctl_ack_i,
    input  logic                  ctl_ack_raw_i,
    input  logic [DATA_W-1:0]     ctl_dat_i,
    input  logic [DATA_W-1:0]     ctl_dat_raw_i,
    input  logic                  ctl_idle_i,
    output logic                  ctl_refresh_inhibit_o,
    output logic                  ctl_pause_read_o
);

    logic [1:0]            state_q,   state_d;
    logic                  acc_q,     acc_d;
    logic                  we_q,      we_d;
    logic [ADDR_WIDTH-1:0] adr_q,     adr_d;
    logic [DATA_W-1:0]     dat_q,     dat_d;
    logic [SEL_W-1:0]      sel_q,     sel_d;
    logic                  orphan_q,  orphan_d;
    logic                  inhibit_q, inhibit_d;

    logic grant0;
    logic grant1;
    logic ack_cycle;
    logic load;
    logic winner;
    logic withdrawn;

    assign grant0    = (state_q == ST_GRANT0);
    assign grant1    = (state_q == ST_GRANT1);
    assign ack_cycle = (grant0 || grant1) && ctl_ack_i;
    // New work starts from IDLE only when the controller is free, or
    // back-to-back in the cycle the current access is acknowledged.
    assign load      = (p0_acc_i || p1_acc_i)
                       && (((state_q == ST_IDLE) && ctl_idle_i) || ack_cycle);
    assign withdrawn = (grant0 && !p0_acc_i) || (grant1 && !p1_acc_i);

    sdram_arb_prio #(
        .MAX_STARVE (MAX_STARVE),
        .STARVE_W   (STARVE_W)
    ) u_prio (
        .clk      (sdram_clk),
        .rst_n    (sdram_rst_n),
        .p0_req_i (p0_acc_i),
        .p1_req_i (p1_acc_i),
        .load_i   (load),
        .winner_o (winner)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        orphan_d  = orphan_q;
        inhibit_d = p0_hold_i;
        if (load) begin
            state_d  = state_for_grant(winner);
            acc_d    = 1'b1;
            orphan_d = 1'b0;
            if (winner == GNT_P0) begin
                we_d  = 1'b0;
                adr_d = p0_adr_i;
                dat_d = '0;
                sel_d = SEL_FULL_WORD;
            end else begin
                we_d  = p1_we_i;
                adr_d = p1_adr_i;
                dat_d = p1_dat_i;
                sel_d = p1_sel_i;
            end
        end else if (ack_cycle) begin
            state_d  = ST_IDLE;
            acc_d    = 1'b0;
            orphan_d = 1'b0;
        end else if (withdrawn) begin
            // The controller access is never aborted; its ack is dropped later.
            orphan_d = 1'b1;
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            orphan_q  <= 1'b0;
            inhibit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            orphan_q  <= orphan_d;
            inhibit_q <= inhibit_d;
        end
    end

    // Masking acc in the ack cycle keeps the controller from starting a duplicate.
    assign ctl_acc_o             = acc_q && !ctl_ack_i;
    assign ctl_we_o              = we_q;
    assign ctl_adr_o             = adr_q;
    assign ctl_dat_o             = dat_q;
    assign ctl_sel_o             = sel_q;
    assign ctl_refresh_inhibit_o = inhibit_q;
    assign ctl_pause_read_o      = p0_pause_i && grant0;

    assign p0_ack_o     = grant0 && ctl_ack_i && !orphan_q;
    assign p0_ack_raw_o = grant0 && ctl_ack_raw_i && !ctl_ack_i && !orphan_q;
    assign p0_dat_o     = p0_ack_o ? ctl_dat_i : (p0_ack_raw_o ? ctl_dat_raw_i : '0);
    assign p1_ack_o     = grant1 && ctl_ack_i && !orphan_q;
    assign p1_dat_o     = p1_ack_o ? ctl_dat_i : '0;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: behavioural SDRAM controller, byte-level reference
// memory and directed plus randomized requester traffic.
module tb_sdram_arbiter;

    localparam int MAX_STARVE = 4;
    localparam int REF_T      = 30;

    logic        sdram_clk = 1'b0;
    logic        sdram_rst_n;
    logic        p0_acc, p0_hold, p0_pause;
    logic [31:0] p0_adr;
    logic        p0_ack_o, p0_ack_raw_o;
    logic [15:0] p0_dat_o;
    logic        p1_acc, p1_we;
    logic [31:0] p1_adr;
    logic [15:0] p1_dat;
    logic [1:0]  p1_sel;
    logic        p1_ack_o;
    logic [15:0] p1_dat_o;
    logic        ctl_acc_o, ctl_we_o;
    logic [31:0] ctl_adr_o;
    logic [15:0] ctl_dat_o;
    logic [1:0]  ctl_sel_o;
    logic        ctl_ack, ctl_ack_raw, ctl_idle;
    logic [15:0] ctl_dat, ctl_dat_raw;
    logic        ctl_refresh_inhibit_o, ctl_pause_read_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 sdram_clk = ~sdram_clk;

    sdram_arbiter dut (
        .sdram_clk             (sdram_clk),
        .sdram_rst_n           (sdram_rst_n),
        .p0_acc_i              (p0_acc),
        .p0_adr_i              (p0_adr),
        .p0_ack_o              (p0_ack_o),
        .p0_ack_raw_o          (p0_ack_raw_o),
        .p0_dat_o              (p0_dat_o),
        .p0_hold_i             (p0_hold),
        .p0_pause_i            (p0_pause),
        .p1_acc_i              (p1_acc),
        .p1_we_i               (p1_we),
        .p1_adr_i              (p1_adr),
        .p1_dat_i              (p1_dat),
        .p1_sel_i              (p1_sel),
        .p1_ack_o              (p1_ack_o),
        .p1_dat_o              (p1_dat_o),
        .ctl_acc_o             (ctl_acc_o),
        .ctl_we_o              (ctl_we_o),
        .ctl_adr_o             (ctl_adr_o),
        .ctl_dat_o             (ctl_dat_o),
        .ctl_sel_o             (ctl_sel_o),
        .ctl_ack_i             (ctl_ack),
        .ctl_ack_raw_i         (ctl_ack_raw),
        .ctl_dat_i             (ctl_dat),
        .ctl_dat_raw_i         (ctl_dat_raw),
        .ctl_idle_i            (ctl_idle),
        .ctl_refresh_inhibit_o (ctl_refresh_inhibit_o),
        .ctl_pause_read_o      (ctl_pause_read_o)
    );

    function automatic logic [15:0] init_word(input logic [31:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    // ---------------- behavioural controller ----------------
    logic [15:0] cmem [logic [31:0]];
    logic [31:0] log_adr [$];
    int          m_phase, m_cnt, ref_cnt, ref_busy;
    int          refresh_cnt = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic        m_we;
    logic [31:0] m_adr;
    logic [15:0] m_dat, old_w;
    logic [1:0]  m_sel;

    function automatic logic [15:0] ctl_rd(input logic [31:0] a);
        return cmem.exists(a) ? cmem[a] : init_word(a);
    endfunction

    assign ctl_idle = (m_phase == 0) && (ref_busy == 0);

    always @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            m_phase     <= 0;
            m_cnt       <= 0;
            ref_cnt     <= 0;
            ref_busy    <= 0;
            ctl_ack     <= 1'b0;
            ctl_ack_raw <= 1'b0;
            ctl_dat     <= '0;
            ctl_dat_raw <= '0;
        end else begin
            ctl_ack     <= 1'b0;
            ctl_ack_raw <= 1'b0;
            if (ref_cnt < 255) ref_cnt <= ref_cnt + 1;
            if (ref_busy != 0) ref_busy <= ref_busy - 1;
            case (m_phase)
                0: begin
                    if (ref_busy == 0 && ctl_acc_o) begin
                        m_we  <= ctl_we_o;
                        m_adr <= ctl_adr_o;
                        m_dat <= ctl_dat_o;
                        m_sel <= ctl_sel_o;
                        log_adr.push_back(ctl_adr_o);
                        m_cnt   <= 1;
                        m_phase <= 1;
                    end else if (ref_busy == 0 && ref_cnt >= REF_T && !ctl_refresh_inhibit_o) begin
                        ref_busy    <= 4;
                        ref_cnt     <= 0;
                        refresh_cnt <= refresh_cnt + 1;
                    end
                end
                1: begin
                    if (m_cnt == 0) begin
                        if (!m_we) begin
                            ctl_ack_raw <= 1'b1;
                            ctl_dat_raw <= ctl_rd(m_adr);
                        end
                        m_phase <= 2;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                default: begin
                    ctl_ack <= 1'b1;
                    if (m_we) begin
                        old_w = ctl_rd(m_adr);
                        cmem[m_adr] = {m_sel[1] ? m_dat[15:8] : old_w[15:8],
                                       m_sel[0] ? m_dat[7:0]  : old_w[7:0]};
                        wr_cnt  <= wr_cnt + 1;
                        ctl_dat <= '0;
                    end else begin
                        ctl_dat <= ctl_rd(m_adr);
                    end
                    done_cnt <= done_cnt + 1;
                    m_phase  <= 0;
                end
            endcase
        end
    end

    // ---------------- byte-level reference memory ----------------
    logic [7:0] ref_b [logic [32:0]];

    function automatic logic [15:0] ref_rd(input logic [31:0] a);
        logic [15:0] w;
        w = init_word(a);
        if (ref_b.exists({a, 1'b0})) w[7:0]  = ref_b[{a, 1'b0}];
        if (ref_b.exists({a, 1'b1})) w[15:8] = ref_b[{a, 1'b1}];
        return w;
    endfunction

    task automatic ref_wr(input logic [31:0] a, input logic [15:0] d, input logic [1:0] s);
        if (s[0]) ref_b[{a, 1'b0}] = d[7:0];
        if (s[1]) ref_b[{a, 1'b1}] = d[15:8];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic p0_read(input logic [31:0] adr, output logic [15:0] rd, output bit ok,
                           output int acc_lat, output bit raw_before, output bit acc_low,
                           output bit pause_seen);
        bit prev_raw, seen_acc;
        rd = '0; ok = 0; acc_lat = -1; raw_before = 0; acc_low = 0; pause_seen = 0;
        prev_raw = 0; seen_acc = 0;
        @(negedge sdram_clk);
        p0_adr = adr;
        p0_acc = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge sdram_clk);
            if (!seen_acc && ctl_acc_o) begin
                seen_acc   = 1;
                acc_lat    = i + 1;
                pause_seen = ctl_pause_read_o;
            end
            if (p0_ack_o) begin
                ok         = 1;
                rd         = p0_dat_o;
                raw_before = prev_raw;
                acc_low    = !ctl_acc_o;
                break;
            end
            prev_raw = p0_ack_raw_o;
        end
        p0_acc = 1'b0;
    endtask

    task automatic p1_xfer(input bit we, input logic [31:0] adr, input logic [15:0] dat,
                           input logic [1:0] sel, output logic [15:0] rd, output bit ok,
                           output bit pause_seen);
        bit seen_acc;
        rd = '0; ok = 0; pause_seen = 0; seen_acc = 0;
        @(negedge sdram_clk);
        p1_we  = we;
        p1_adr = adr;
        p1_dat = dat;
        p1_sel = sel;
        p1_acc = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge sdram_clk);
            if (!seen_acc && ctl_acc_o) begin
                seen_acc   = 1;
                pause_seen = ctl_pause_read_o;
            end
            if (p1_ack_o) begin
                ok = 1;
                rd = p1_dat_o;
                break;
            end
        end
        p1_acc = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic [31:0] a;
        logic [15:0] d;
        logic [1:0]  s;
        bit          ok, raw_before, acc_low, pause_seen, seen, busy_seen;
        int          lat, n0, wr0, rc0, dn0, kind;

        sdram_rst_n = 1'b0;
        p0_acc = 0; p0_adr = '0; p0_hold = 0; p0_pause = 0;
        p1_acc = 0; p1_we = 0; p1_adr = '0; p1_dat = '0; p1_sel = '0;
        repeat (3) @(negedge sdram_clk);
        chk("reset_ctrl_bits", {ctl_acc_o, ctl_we_o, ctl_sel_o, ctl_refresh_inhibit_o,
                                ctl_pause_read_o, p0_ack_o, p0_ack_raw_o, p1_ack_o}, 32'h0);
        chk("reset_ctl_adr", ctl_adr_o, 32'h0);
        chk("reset_dat_outs", {ctl_dat_o, p0_dat_o}, 32'h0);
        sdram_rst_n = 1'b1;
        repeat (2) @(negedge sdram_clk);

        // single port-0 read
        p0_pause = 1'b1;
        p0_read(32'h0000_0100, rd, ok, lat, raw_before, acc_low, pause_seen);
        p0_pause = 1'b0;
        chk("p0_first_ack", ok, 1);
        chk("p0_acc_latency", lat, 1);
        chk("p0_raw_then_ack", raw_before, 1);
        chk("p0_acc_low_in_ack", acc_low, 1);
        chk("p0_first_data", rd, ref_rd(32'h0000_0100));
        chk("p0_pause_in_grant0", pause_seen, 1);

        // port-1 write then read back: exactly one controller write
        wr0 = wr_cnt;
        p1_xfer(1, 32'h0000_0200, 16'hBEEF, 2'b01, rd, ok, pause_seen);
        ref_wr(32'h0000_0200, 16'hBEEF, 2'b01);
        chk("p1_write_ack", ok, 1);
        repeat (6) @(negedge sdram_clk);
        chk("p1_single_write", wr_cnt - wr0, 1);
        p0_pause = 1'b1;
        p1_xfer(0, 32'h0000_0200, 16'h0000, 2'b00, rd, ok, pause_seen);
        p0_pause = 1'b0;
        chk("p1_read_ack", ok, 1);
        chk("p1_read_low_byte", rd[7:0], 8'hEF);
        chk("p1_read_word", rd, ref_rd(32'h0000_0200));
        chk("p1_no_pause_grant1", pause_seen, 0);

        // both ports requesting continuously from the same cycle
        n0 = log_adr.size();
        @(negedge sdram_clk);
        p0_adr = 32'h0000_1000; p0_acc = 1'b1;
        p1_adr = 32'h0000_2000; p1_we = 1'b0; p1_sel = 2'b11; p1_acc = 1'b1;
        for (int i = 0; i < 600 && log_adr.size() < n0 + 10; i++) @(negedge sdram_clk);
        p0_acc = 1'b0;
        p1_acc = 1'b0;
        chk("fair_grant_count", log_adr.size() >= n0 + 10, 1);
        for (int k = 0; k < 10; k++) begin
            a = ((k + 1) % (MAX_STARVE + 1) == 0) ? 32'h0000_2000 : 32'h0000_1000;
            if (n0 + k < log_adr.size()) chk($sformatf("fair_grant_%0d", k), log_adr[n0 + k], a);
            else chk($sformatf("fair_grant_%0d", k), 32'hFFFF_FFFF, a);
        end
        repeat (20) @(negedge sdram_clk);

        // refresh held off while port 0 is in its critical window
        p0_hold = 1'b1;
        repeat (3) @(negedge sdram_clk);
        rc0 = refresh_cnt;
        busy_seen = 0;
        for (int i = 0; i < 3 * REF_T; i++) begin
            @(negedge sdram_clk);
            if (!ctl_idle) busy_seen = 1;
        end
        chk("hold_inhibit_out", ctl_refresh_inhibit_o, 1);
        chk("hold_no_refresh", refresh_cnt - rc0, 0);
        chk("hold_idle_steady", busy_seen, 0);
        p0_hold = 1'b0;
        repeat (REF_T) @(negedge sdram_clk);
        chk("refresh_after_hold", refresh_cnt > rc0, 1);
        chk("inhibit_released", ctl_refresh_inhibit_o, 0);
        repeat (6) @(negedge sdram_clk);

        // port 1 withdraws one cycle after its grant
        dn0 = done_cnt;
        @(negedge sdram_clk);
        p1_adr = 32'h0000_0300; p1_we = 1'b0; p1_sel = 2'b11; p1_acc = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge sdram_clk);
            seen = ctl_acc_o;
        end
        chk("orphan_granted", seen, 1);
        @(negedge sdram_clk);
        p1_acc = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sdram_clk);
            if (p1_ack_o) seen = 1;
        end
        chk("orphan_ack_swallowed", seen, 0);
        chk("orphan_ctl_completed", done_cnt - dn0, 1);
        p0_read(32'h0000_0104, rd, ok, lat, raw_before, acc_low, pause_seen);
        chk("after_orphan_p0_ack", ok, 1);
        chk("after_orphan_p0_data", rd, ref_rd(32'h0000_0104));

        // reset while port 1 waits for its ack
        wr0 = wr_cnt;
        @(negedge sdram_clk);
        p1_adr = 32'h0000_0400; p1_we = 1'b1; p1_dat = 16'h1234; p1_sel = 2'b11; p1_acc = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge sdram_clk);
            seen = ctl_acc_o;
        end
        chk("rst_test_granted", seen, 1);
        sdram_rst_n = 1'b0;
        #1;
        chk("midrst_ctrl_bits", {ctl_acc_o, ctl_we_o, ctl_sel_o, p1_ack_o, p0_ack_o}, 32'h0);
        chk("midrst_adr", ctl_adr_o, 32'h0);
        chk("midrst_dat", {ctl_dat_o, p1_dat_o}, 32'h0);
        p1_acc = 1'b0;
        repeat (2) @(negedge sdram_clk);
        sdram_rst_n = 1'b1;
        repeat (2) @(negedge sdram_clk);
        chk("midrst_no_write", wr_cnt - wr0, 0);
        p0_read(32'h0000_0400, rd, ok, lat, raw_before, acc_low, pause_seen);
        chk("post_rst_p0_ack", ok, 1);
        chk("post_rst_p0_data", rd, ref_rd(32'h0000_0400));

        // randomized mixed traffic against the reference memory
        for (int t = 0; t < 20; t++) begin
            kind = $urandom_range(0, 2);
            a = 32'h0000_0040 + 32'($urandom_range(0, 7));
            d = 16'($urandom);
            s = 2'($urandom_range(0, 3));
            if (kind == 0) begin
                p0_read(a, rd, ok, lat, raw_before, acc_low, pause_seen);
                chk($sformatf("rnd%0d_p0_rd", t), {ok, 15'h0, rd}, {1'b1, 15'h0, ref_rd(a)});
            end else if (kind == 1) begin
                p1_xfer(0, a, 16'h0, 2'b11, rd, ok, pause_seen);
                chk($sformatf("rnd%0d_p1_rd", t), {ok, 15'h0, rd}, {1'b1, 15'h0, ref_rd(a)});
            end else begin
                p1_xfer(1, a, d, s, rd, ok, pause_seen);
                ref_wr(a, d, s);
                chk($sformatf("rnd%0d_p1_wr", t), ok, 1);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
